mem_bus_arbiter: RTL
====================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ADDR_W, 28, block-address width on all ports.
REQ-002 Parameter BLOCK_W, 128, data-block width on all ports.
REQ-003 CLK  input  1  rising-edge clock.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 I_READ  input  1  instruction-cache block read request, held until I_BUSYWAIT low.
REQ-006 I_ADDRESS  input  ADDR_W  instruction-cache block address.
REQ-007 I_READDATA  output  BLOCK_W  registered block returned to instruction cache.
REQ-008 I_BUSYWAIT  output  1  instruction-cache stall.
REQ-009 D_READ / D_WRITE  input  1 each  data-cache read / write-back request, held until D_BUSYWAIT low.
REQ-010 D_ADDRESS  input  ADDR_W; D_WRITEDATA  input  BLOCK_W  data-cache address and write block.
REQ-011 D_READDATA  output  BLOCK_W  registered block returned to data cache.
REQ-012 D_BUSYWAIT  output  1  data-cache stall; feeds the pipeline-register BUSYWAIT hold.
REQ-013 MEM_READ / MEM_WRITE  output  1 each  registered main-memory request strobes.
REQ-014 MEM_ADDRESS  output  ADDR_W; MEM_WRITEDATA  output  BLOCK_W  registered memory address and data.
REQ-015 MEM_READDATA  input  BLOCK_W; MEM_BUSYWAIT  input  1  memory response; MEM_BUSYWAIT is high from the first cycle a strobe is high until the operation completes.

Function
REQ-016 The FSM SHALL have states IDLE, GRANT_I, GRANT_D, RESP_I, RESP_D.
REQ-017 IDLE: on a rising edge with any request pending, go to GRANT_D or GRANT_I per REQ-023, loading MEM_* from the winner; D_WRITE wins over D_READ if both are high.
REQ-018 GRANT_x: hold MEM_* stable; on the first edge with MEM_BUSYWAIT=0, capture MEM_READDATA into x_READDATA (reads only), drop strobes, go to RESP_x.
REQ-019 RESP_x: x_BUSYWAIT SHALL be 0 for exactly this one cycle; next edge -> IDLE.
REQ-020 x_BUSYWAIT SHALL equal (x request high) AND NOT (state==RESP_x), combinationally, so a new request stalls in its own cycle.
REQ-021 Minimum latency request->BUSYWAIT low is 2 cycles plus memory busy cycles; back-to-back requests re-enter IDLE for one cycle.
REQ-022 x_READDATA SHALL hold its last captured value until the next completed read for x; writes do not alter D_READDATA.
REQ-023 Default priority: D beats I when both are pending in IDLE.
REQ-024 A request dropped while granted SHALL still complete on the memory side; the result is discarded and the FSM returns to IDLE without entering RESP.
REQ-025 Requests arriving during GRANT/RESP of the other port SHALL wait; no starvation beyond one transaction under round-robin.

Reset
REQ-026 RESET_N low SHALL immediately force IDLE, MEM_READ=0, MEM_WRITE=0, MEM_ADDRESS=0, MEM_WRITEDATA=0, I_READDATA=0, D_READDATA=0, last-grant=I.
REQ-027 Reset mid-transaction SHALL abandon it; after release, pending requests restart from IDLE.

Configuration
REQ-028 Macro MEM_ARB_ROUND_ROBIN_EN defined: on a simultaneous request the port not granted last wins, and last-grant updates on every grant.
REQ-029 Macro undefined: fixed D priority per REQ-023; last-grant register is not built.

Structure
REQ-030 Package mem_arb_pkg SHALL hold the state enumeration, default ADDR_W/BLOCK_W, and the port-ID constants PORT_I/PORT_D.
REQ-031 The winner selection SHALL be a combinational sub-module arb_grant_sel (inputs: requests, last-grant; output: winner).

Verification
REQ-032 I_READ addr 0x10, MEM_BUSYWAIT high 3 cycles, data 0xA5..A5 -> MEM_READ high 4 cycles, I_BUSYWAIT low for one cycle, I_READDATA=0xA5..A5.
REQ-033 D_WRITE and I_READ in the same cycle, fixed priority -> D serviced first (MEM_WRITE, D_WRITEDATA forwarded), then I; I_BUSYWAIT high throughout D.
REQ-034 With MEM_ARB_ROUND_ROBIN_EN: three simultaneous D_READ+I_READ pairs -> grant order D, I, D.
REQ-035 RESET_N low during GRANT_D -> MEM_READ=0 and state IDLE without waiting for a clock; D request still held -> re-granted after release.
REQ-036 I_READ dropped in GRANT_I -> memory completes, I_READDATA unchanged, FSM in IDLE next cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port (I/D cache) main-memory arbiter.
// Optional round-robin arbitration is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_GRANT_I = 3'd1,
    ST_GRANT_D = 3'd2,
    ST_RESP_I  = 3'd3,
    ST_RESP_D  = 3'd4
  } arb_state_t;

  localparam int DEF_ADDR_W  = 28;
  localparam int DEF_BLOCK_W = 128;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/arb_grant_sel.sv
// Combinational winner selection between the I and D cache requests.
// MEM_ARB_ROUND_ROBIN_EN: a tie goes to the port not granted last; otherwise D always wins.
module arb_grant_sel
  import mem_arb_pkg::*;
(
  input  logic i_req_i,
  input  logic i_req_d,
  input  logic i_last_grant,
  output logic o_winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  always_comb begin
    o_winner = PORT_I;
    if (i_req_i && i_req_d) begin
      o_winner = ~i_last_grant;
    end else if (i_req_d) begin
      o_winner = PORT_D;
    end
  end
`else
  // Fixed priority has no use for the last-grant history.
  logic w_unused_last;
  assign w_unused_last = i_last_grant;
  assign o_winner      = i_req_d ? PORT_D : PORT_I;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates instruction- and data-cache block requests onto one main-memory port.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed D-over-I priority.
//
// Handshake: a cache holds its request (and address/data) until its BUSYWAIT drops;
// BUSYWAIT is low for exactly the single RESP cycle, and the cache drops or changes its
// request at the following edge. Memory holds MEM_BUSYWAIT high while an operation runs.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BLOCK_W = DEF_BLOCK_W
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               I_READ,
  input  logic [ADDR_W-1:0]  I_ADDRESS,
  output logic [BLOCK_W-1:0] I_READDATA,
  output logic               I_BUSYWAIT,
  input  logic               D_READ,
  input  logic               D_WRITE,
  input  logic [ADDR_W-1:0]  D_ADDRESS,
  input  logic [BLOCK_W-1:0] D_WRITEDATA,
  output logic [BLOCK_W-1:0] D_READDATA,
  output logic               D_BUSYWAIT,
  output logic               MEM_READ,
  output logic               MEM_WRITE,
  output logic [ADDR_W-1:0]  MEM_ADDRESS,
  output logic [BLOCK_W-1:0] MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0] MEM_READDATA,
  input  logic               MEM_BUSYWAIT,
  output logic [2:0]         o_dbg_state
);

  arb_state_t         r_state;
  logic               r_mem_read;
  logic               r_mem_write;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [BLOCK_W-1:0] r_mem_wdata;
  logic [BLOCK_W-1:0] r_i_rdata;
  logic [BLOCK_W-1:0] r_d_rdata;

  logic w_d_req;
  logic w_winner;
  logic w_last_grant;

  assign w_d_req = D_READ | D_WRITE;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last_grant;
  assign w_last_grant = r_last_grant;
`else
  assign w_last_grant = PORT_I;
`endif

  arb_grant_sel u_grant_sel (
    .i_req_i      (I_READ),
    .i_req_d      (w_d_req),
    .i_last_grant (w_last_grant),
    .o_winner     (w_winner)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state     <= ST_IDLE;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      r_last_grant <= PORT_I;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (I_READ || w_d_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            r_last_grant <= w_winner;
`endif
            if (w_winner == PORT_D) begin
              r_state     <= ST_GRANT_D;
              r_mem_write <= D_WRITE;
              r_mem_read  <= ~D_WRITE;
              r_mem_addr  <= D_ADDRESS;
              r_mem_wdata <= D_WRITEDATA;
            end else begin
              r_state     <= ST_GRANT_I;
              r_mem_write <= 1'b0;
              r_mem_read  <= 1'b1;
              r_mem_addr  <= I_ADDRESS;
            end
          end
        end
        ST_GRANT_I: begin
          if (!MEM_BUSYWAIT) begin
            r_mem_read <= 1'b0;
            // A request withdrawn mid-grant still finishes on memory; its data is dropped.
            if (I_READ) begin
              r_i_rdata <= MEM_READDATA;
              r_state   <= ST_RESP_I;
            end else begin
              r_state   <= ST_IDLE;
            end
          end
        end
        ST_GRANT_D: begin
          if (!MEM_BUSYWAIT) begin
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            if (w_d_req) begin
              if (r_mem_read) begin
                r_d_rdata <= MEM_READDATA;
              end
              r_state <= ST_RESP_D;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_RESP_I: r_state <= ST_IDLE;
        ST_RESP_D: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  assign I_BUSYWAIT    = I_READ  && (r_state != ST_RESP_I);
  assign D_BUSYWAIT    = w_d_req && (r_state != ST_RESP_D);
  assign MEM_READ      = r_mem_read;
  assign MEM_WRITE     = r_mem_write;
  assign MEM_ADDRESS   = r_mem_addr;
  assign MEM_WRITEDATA = r_mem_wdata;
  assign I_READDATA    = r_i_rdata;
  assign D_READDATA    = r_d_rdata;
  assign o_dbg_state   = r_state;

endmodule
